// File: rtl/mips_isa_pkg.sv
// Shared MIPS ISA definitions: symbolic op codes, opcode/funct fields, IM write entry.
// Pure declarations, no timing; imported by the encoder and the control decoder.
package mips_isa_pkg;

  typedef enum logic [3:0] {
    OP_NOP = 4'd0,
    OP_ADD = 4'd1,
    OP_SUB = 4'd2,
    OP_ORI = 4'd3,
    OP_LW  = 4'd4,
    OP_SW  = 4'd5,
    OP_BEQ = 4'd6,
    OP_LUI = 4'd7,
    OP_JAL = 4'd8,
    OP_JR  = 4'd9
  } op_e;

  localparam logic [5:0] OPC_ALU = 6'h00;
  localparam logic [5:0] OPC_ORI = 6'h0D;
  localparam logic [5:0] OPC_LW  = 6'h23;
  localparam logic [5:0] OPC_SW  = 6'h2B;
  localparam logic [5:0] OPC_BEQ = 6'h04;
  localparam logic [5:0] OPC_LUI = 6'h0F;
  localparam logic [5:0] OPC_JAL = 6'h03;

  localparam logic [5:0] FUNCT_ADD = 6'h20;
  localparam logic [5:0] FUNCT_SUB = 6'h22;
  localparam logic [5:0] FUNCT_JR  = 6'h08;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } im_entry_t;

  function automatic logic op_is_valid(input logic [3:0] op);
    return op <= OP_JR;
  endfunction

endpackage

// File: rtl/instr_skid_buf.sv
// 2-entry 64-bit FIFO with push/pop/flush; head visible the cycle after a push into empty.
// Push is dropped when full unless a pop frees the slot in the same cycle; flush wins over both.
module instr_skid_buf (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        flush,
  input  logic        push,
  input  logic [63:0] push_dat,
  input  logic        pop,
  output logic [63:0] head_dat,
  output logic [1:0]  occupancy
);

  logic [1:0][63:0] mem_q, mem_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       cnt_q, cnt_d;
  logic             push_en, pop_en, wr_idx;

  assign pop_en    = pop && (cnt_q != 2'd0);
  assign push_en   = push && ((cnt_q != 2'd2) || pop_en);
  // With two slots the tail is head xor the low count bit; at count 2 it aliases the slot being popped.
  assign wr_idx    = rd_ptr_q ^ cnt_q[0];
  assign head_dat  = mem_q[rd_ptr_q];
  assign occupancy = cnt_q;

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush) begin
      rd_ptr_d = 1'b0;
      cnt_d    = 2'd0;
    end else begin
      if (push_en) mem_d[wr_idx] = push_dat;
      if (pop_en)  rd_ptr_d = ~rd_ptr_q;
      cnt_d = cnt_q + {1'b0, push_en} - {1'b0, pop_en};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_q    <= '0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/mips_instr_encoder.sv
// Encodes symbolic MIPS requests and streams {addr, word} writes into IM from BASE_ADDR.
// Accept-to-im_valid latency 1 when empty; req_ready drops when buffer holds 2, when full, or during clear.
module mips_instr_encoder
  import mips_isa_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_3000,
  parameter int          DEPTH     = 1024,
  localparam int         CW        = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          clear,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [3:0]    req_op,
  input  logic [4:0]    req_rs,
  input  logic [4:0]    req_rt,
  input  logic [4:0]    req_rd,
  input  logic [15:0]   req_imm,
  input  logic [25:0]   req_target,
  output logic          im_valid,
  input  logic          im_ready,
  output logic [31:0]   im_addr,
  output logic [31:0]   im_wdata,
  output logic [CW-1:0] word_count,
  output logic          full,
  output logic          err_invalid
);

  function automatic logic [31:0] encode(
    input logic [3:0]  op,
    input logic [4:0]  rs,
    input logic [4:0]  rt,
    input logic [4:0]  rd,
    input logic [15:0] imm,
    input logic [25:0] target
  );
    logic [31:0] w;
    w = 32'h0;
    case (op)
      OP_ADD:  w = {OPC_ALU, rs, rt, rd, 5'h0, FUNCT_ADD};
      OP_SUB:  w = {OPC_ALU, rs, rt, rd, 5'h0, FUNCT_SUB};
      OP_ORI:  w = {OPC_ORI, rs, rt, imm};
      OP_LW:   w = {OPC_LW,  rs, rt, imm};
      OP_SW:   w = {OPC_SW,  rs, rt, imm};
      OP_BEQ:  w = {OPC_BEQ, rs, rt, imm};
      OP_LUI:  w = {OPC_LUI, 5'h0, rt, imm};
      OP_JAL:  w = {OPC_JAL, target};
      OP_JR:   w = {OPC_ALU, rs, 15'h0, FUNCT_JR};
      default: w = 32'h0;
    endcase
    return w;
  endfunction

  logic [CW-1:0] word_count_q, word_count_d;
  logic          err_q, err_d;
  logic [1:0]    occ;
  logic [63:0]   head_raw;
  im_entry_t     head, push_entry;
  logic          accept, op_ok, push, pop;

  assign full = (word_count_q == CW'(DEPTH));
  // Reset gates ready combinationally so no request slips in while reset_n is low.
  assign req_ready = reset_n && !full && (occ != 2'd2) && !clear;
  assign accept    = req_valid && req_ready;
  assign op_ok     = op_is_valid(req_op);
  assign push      = accept && op_ok;

  assign push_entry.addr = BASE_ADDR + (32'(word_count_q) << 2);
  assign push_entry.data = encode(req_op, req_rs, req_rt, req_rd, req_imm, req_target);

  assign head     = im_entry_t'(head_raw);
  assign im_valid = (occ != 2'd0);
  assign pop      = im_valid && im_ready;
  assign im_addr  = im_valid ? head.addr : 32'h0;
  assign im_wdata = im_valid ? head.data : 32'h0;

  assign word_count  = word_count_q;
  assign err_invalid = err_q;

  always_comb begin
    word_count_d = word_count_q;
    err_d        = accept && !op_ok;
    if (clear) begin
      word_count_d = '0;
      err_d        = 1'b0;
    end else if (push) begin
      word_count_d = word_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      word_count_q <= '0;
      err_q        <= 1'b0;
    end else begin
      word_count_q <= word_count_d;
      err_q        <= err_d;
    end
  end

  instr_skid_buf u_buf (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (clear),
    .push      (push),
    .push_dat  (push_entry),
    .pop       (pop),
    .head_dat  (head_raw),
    .occupancy (occ)
  );

endmodule
